// File: rtl/exmem_wb_master_if.sv
// Bus bundle between the block master and the exmem slave port.
// Master drives the request; slave answers with ack and read data.
interface exmem_wb_master_if;
  logic        m_valid;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr;
  logic [31:0] m_dat_o;
  logic        m_ack;
  logic [31:0] m_dat_i;

  modport master (
    output m_valid, m_we, m_sel, m_adr, m_dat_o,
    input  m_ack, m_dat_i
  );

  modport slave (
    input  m_valid, m_we, m_sel, m_adr, m_dat_o,
    output m_ack, m_dat_i
  );
endinterface

// File: rtl/exmem_wb_master.sv
// Block-transfer initiator for the exmem slave port: streams write
// words onto the bus or gathers read words into a small FIFO.
module exmem_wb_master #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done,
  output logic             busy,
  exmem_wb_master_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_BUS, RD_BUS, RD_STALL, FINISH
  } state_t;

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic             m_valid_q;
  logic             m_we_q;
  logic [3:0]       m_sel_q;
  logic [31:0]      m_adr_q;
  logic [31:0]      m_dat_q;
  logic             done_q;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             ack, last, push, pop, full;
  logic [31:0]      addr_nxt;
  logic [31:0]      cmd_base;

  assign ack      = bus.m_ack & m_valid_q;
  assign last     = rem_q == LEN_W'(1);
  assign addr_nxt = addr_q + 32'd4;
  assign cmd_base = {cmd_addr[31:2], 2'b00};

  assign push  = (state_q == RD_BUS) & ack;
  assign pop   = rd_valid & rd_ready;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign wr_ready  = state_q == WR_FETCH;
  assign done      = done_q;
  assign rd_valid  = cnt_q != '0;
  assign rd_data   = mem_q[rp_q];

  assign bus.m_valid = m_valid_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_sel   = m_sel_q;
  assign bus.m_adr   = m_adr_q;
  assign bus.m_dat_o = m_dat_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_sel_q   <= '0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q <= cmd_base;
          rem_q  <= cmd_len;
          if (cmd_len == '0) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else if (cmd_we) begin
            state_q <= WR_FETCH;
          end else begin
            m_we_q  <= 1'b0;
            m_sel_q <= 4'h0;
            m_adr_q <= cmd_base;
            // only request when a FIFO slot is already free
            if (!full) begin
              state_q   <= RD_BUS;
              m_valid_q <= 1'b1;
            end else begin
              state_q <= RD_STALL;
            end
          end
        end
        WR_FETCH: if (wr_valid) begin
          m_dat_q   <= wr_data;
          m_adr_q   <= addr_q;
          m_we_q    <= 1'b1;
          m_sel_q   <= 4'hF;
          m_valid_q <= 1'b1;
          state_q   <= WR_BUS;
        end
        WR_BUS: if (ack) begin
          addr_q    <= addr_nxt;
          rem_q     <= rem_q - LEN_W'(1);
          m_valid_q <= 1'b0;
          if (last) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= WR_FETCH;
          end
        end
        RD_BUS: if (ack) begin
          addr_q <= addr_nxt;
          rem_q  <= rem_q - LEN_W'(1);
          if (last) begin
            m_valid_q <= 1'b0;
            state_q   <= FINISH;
            done_q    <= 1'b1;
          end else if (cnt_d < CW'(FIFO_DEPTH)) begin
            m_adr_q <= addr_nxt;
          end else begin
            m_valid_q <= 1'b0;
            state_q   <= RD_STALL;
          end
        end
        RD_STALL: if (!full) begin
          m_adr_q   <= addr_q;
          m_valid_q <= 1'b1;
          state_q   <= RD_BUS;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wp_q] <= bus.m_dat_i;
  end

endmodule

// File: tb/tb_exmem_wb_master.sv
// Directed bench for exmem_wb_master: slave model with
// programmable latency, write feeder and read consumer.
module tb_exmem_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        done, busy;

  exmem_wb_master_if bus();

  exmem_wb_master #(.LEN_W(16), .FIFO_DEPTH(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .done     (done),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slave model
  int          lat = 1;
  logic [31:0] rd_off = 0;
  int          wcnt = 0;
  int          vcyc = 0;
  int          stab_bad = 0;
  logic [31:0] h_adr, h_dat;
  logic [3:0]  h_sel;
  logic        h_we;
  logic [31:0] tx_adr[$], tx_dat[$];
  logic [3:0]  tx_sel[$];
  logic        tx_we[$];

  initial begin
    bus.m_ack   = 1'b0;
    bus.m_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.m_ack) begin
        bus.m_ack = 1'b0;
        wcnt = 0;
      end else if (bus.m_valid) begin
        if (wcnt == 0) begin
          h_adr = bus.m_adr; h_dat = bus.m_dat_o;
          h_sel = bus.m_sel; h_we  = bus.m_we;
        end else if (h_adr !== bus.m_adr || h_dat !== bus.m_dat_o ||
                     h_sel !== bus.m_sel || h_we !== bus.m_we) begin
          stab_bad++;
        end
        vcyc++;
        wcnt++;
        if (wcnt >= lat) begin
          bus.m_ack   = 1'b1;
          bus.m_dat_i = (bus.m_adr >> 2) + rd_off;
          tx_adr.push_back(bus.m_adr);
          tx_dat.push_back(bus.m_dat_o);
          tx_sel.push_back(bus.m_sel);
          tx_we.push_back(bus.m_we);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // read consumer and done counter
  logic [31:0] rd_q[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    if (done) done_cnt++;
  end

  // write feeder
  logic [31:0] wq[$];
  int gap = 0;
  int gap_left = 0;
  initial begin
    logic took;
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      took = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (took) begin
        void'(wq.pop_front());
        wr_valid = 1'b0;
        gap_left = gap;
      end
      if (!wr_valid) begin
        if (gap_left > 0) gap_left--;
        else if (wq.size() > 0) begin
          wr_data  = wq[0];
          wr_valid = 1'b1;
        end
      end
    end
  end

  task automatic clear_log();
    tx_adr.delete(); tx_dat.delete();
    tx_sel.delete(); tx_we.delete();
    rd_q.delete();
    vcyc = 0;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] a,
                          input logic [15:0] l);
    cmd_we = we; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 1);
      tick();
      chk("done_one_cyc", done, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  logic [31:0] wv[3];
  int d0;
  logic ok;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_we", bus.m_we, 0);
    chk("rst_sel", bus.m_sel, 0);
    chk("rst_adr", bus.m_adr, 0);
    chk("rst_dat", bus.m_dat_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrrdy", wr_ready, 0);
    chk("rst_rdvld", rd_valid, 0);
    rst = 1'b0;
    tick();
    chk("idle_cmdrdy", cmd_ready, 1);

    // three-word write, 2-cycle slave latency
    clear_log();
    lat = 2; gap = 0;
    wv[0] = 32'hCAFE_00A0; wv[1] = 32'hCAFE_00A1; wv[2] = 32'hCAFE_00A2;
    foreach (wv[i]) wq.push_back(wv[i]);
    send_cmd(1'b1, 32'h0000_0010, 16'd3);
    wait_done(100);
    chk("wr_ntx", tx_adr.size(), 3);
    for (int i = 0; i < 3 && i < tx_adr.size(); i++) begin
      chk("wr_adr", tx_adr[i], 32'h10 + 32'(4 * i));
      chk("wr_dat", tx_dat[i], wv[i]);
      chk("wr_sel", 32'(tx_sel[i]), 32'hF);
      chk("wr_we", 32'(tx_we[i]), 1);
    end
    chk("wr_vcyc", vcyc, 6);

    // four-word read, 5-cycle latency, consumer always ready
    clear_log();
    lat = 5; rd_off = 32'hC0; rd_ready = 1'b1;
    send_cmd(1'b0, 32'h0000_0100, 16'd4);
    wait_done(200);
    chk("rd4_ntx", tx_adr.size(), 4);
    repeat (4) tick();
    chk("rd4_nrd", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      chk("rd4_data", rd_q[i], 32'h100 + 32'(i));
      chk("rd4_sel", 32'(tx_sel[i]), 0);
      chk("rd4_we", 32'(tx_we[i]), 0);
    end

    // twelve-word read with FIFO backpressure
    clear_log();
    lat = 1; rd_off = 0; rd_ready = 1'b0;
    send_cmd(1'b0, 32'h0000_0200, 16'd12);
    repeat (40) tick();
    chk("rd12_stall_ntx", tx_adr.size(), 8);
    chk("rd12_stall_vld", bus.m_valid, 0);
    chk("rd12_stall_busy", busy, 1);
    chk("rd12_stall_rdv", rd_valid, 1);
    rd_ready = 1'b1;
    wait_done(200);
    repeat (10) tick();
    chk("rd12_ntx", tx_adr.size(), 12);
    chk("rd12_nrd", rd_q.size(), 12);
    for (int i = 0; i < 12 && i < rd_q.size(); i++)
      chk("rd12_data", rd_q[i], 32'h80 + 32'(i));

    // write with 3-cycle gaps in the stream
    clear_log();
    lat = 1; gap = 3;
    wv[0] = 32'h1111_00B0; wv[1] = 32'h2222_00B1; wv[2] = 32'h3333_00B2;
    foreach (wv[i]) wq.push_back(wv[i]);
    send_cmd(1'b1, 32'h0000_0043, 16'd3);
    wait_done(100);
    chk("gap_vcyc", vcyc, 3);
    chk("gap_ntx", tx_adr.size(), 3);
    for (int i = 0; i < 3 && i < tx_adr.size(); i++) begin
      chk("gap_adr", tx_adr[i], 32'h40 + 32'(4 * i));
      chk("gap_dat", tx_dat[i], wv[i]);
    end
    gap = 0;

    // zero-length command
    clear_log();
    send_cmd(1'b1, 32'h0000_0500, 16'd0);
    chk("len0_done", done, 1);
    tick();
    chk("len0_done_off", done, 0);
    chk("len0_busy", busy, 0);
    chk("len0_vcyc", vcyc, 0);

    // address wrap
    clear_log();
    rd_ready = 1'b1;
    send_cmd(1'b0, 32'hFFFF_FFF8, 16'd3);
    wait_done(100);
    chk("wrap_ntx", tx_adr.size(), 3);
    if (tx_adr.size() == 3) begin
      chk("wrap_a0", tx_adr[0], 32'hFFFF_FFF8);
      chk("wrap_a1", tx_adr[1], 32'hFFFF_FFFC);
      chk("wrap_a2", tx_adr[2], 32'h0000_0000);
    end
    repeat (4) tick();

    // reset in the middle of a read
    clear_log();
    rd_ready = 1'b0;
    send_cmd(1'b0, 32'h0000_0300, 16'd8);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (tx_adr.size() == 3 && bus.m_valid) ok = 1'b1;
    end
    chk("mrst_setup", ok, 1);
    chk("mrst_pre_rdv", rd_valid, 1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", bus.m_valid, 0);
    chk("mrst_rdv", rd_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cmdrdy", cmd_ready, 1);
    repeat (5) tick();
    chk("mrst_nodone", done_cnt, d0);

    chk("hold_stable", stab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exmem_wb_master.md
Name: exmem_wb_master

Overview:
- Wishbone-style initiator that drives the exmem slave port (valid/we/sel/adr/dat in, ack/dat out).
- Accepts one block command: start address, word count, direction.
- Issues one 32-bit word transaction per word: streams write data from a ready/valid input, or collects read data into an internal FIFO drained by a ready/valid output.
- Sits between a DMA/accelerator stream and the external SDRAM memory path.

Parameters:
- LEN_W, 16, width of command word count (max block = 2^LEN_W-1 words).
- FIFO_DEPTH, 8, read-data FIFO entries (power of two, >=2).

Ports:
- wb_clk_i  in  1  clock; single clock domain.
- wb_rst_i  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1=write block, 0=read block.
- cmd_addr  in  32  byte start address; bits[1:0] ignored (forced 0).
- cmd_len  in  LEN_W  number of words.
- wr_data  in  32  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  write word consumed.
- rd_data  out  32  read stream data (FIFO head).
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pops FIFO head.
- done  out  1  one-cycle pulse when block completes.
- busy  out  1  high whenever not IDLE.
- m_valid  out  1  bus request to slave (wb_valid).
- m_we  out  1  bus write enable.
- m_sel  out  4  byte select; 4'hF during writes, 4'h0 during reads.
- m_adr  out  32  word-aligned bus address.
- m_dat_o  out  32  bus write data.
- m_ack  in  1  slave acknowledge.
- m_dat_i  in  32  slave read data; valid in ack cycle.

Behaviour:
- Reset (sync, wb_rst_i high at edge): state=IDLE, m_valid=0, m_we=0, m_sel=0, m_adr=0, m_dat_o=0, done=0, busy=0, wr_ready=0, FIFO flushed (rd_valid=0). Reset mid-transaction abandons the transfer; m_valid is low the following cycle and no done pulse is issued.
- All m_* outputs are registered. The master holds m_valid, m_we, m_sel, m_adr and m_dat_o stable from assertion until the cycle m_ack=1.
- Ack is taken in the cycle m_ack=1 while m_valid=1. m_ack while m_valid=0 is ignored.
- The master may re-assert m_valid in the cycle after ack with the next address (back-to-back transactions).
- States: IDLE, WR_FETCH, WR_BUS, RD_BUS, RD_STALL, FINISH.
- IDLE: cmd_ready=1.
  - cmd_valid with cmd_len=0 -> FINISH; no bus activity.
  - cmd_we=1 -> WR_FETCH.
  - cmd_we=0 -> RD_BUS if FIFO has space, else RD_STALL.
  - On acceptance, latch: addr = {cmd_addr[31:2],2'b00}, remaining = cmd_len, dir.
- WR_FETCH: wr_ready=1. When wr_valid: latch m_dat_o=wr_data, m_adr=addr, m_we=1, m_sel=F, m_valid=1 -> WR_BUS. wr_ready is combinational (state==WR_FETCH), one word per handshake.
- WR_BUS: wait for m_ack. On ack: addr += 4, remaining -= 1, m_valid=0; next state is FINISH if remaining was 1, else WR_FETCH.
- RD_BUS: m_valid=1, m_we=0, m_sel=0, m_adr=addr.
  - On ack: push m_dat_i into the FIFO, addr += 4, remaining -= 1.
  - Next state: FINISH if last word; else RD_BUS if FIFO free entries after push >=1; else RD_STALL with m_valid=0.
  - A request is only issued when a FIFO slot is guaranteed, so the FIFO never overflows.
- RD_STALL: m_valid=0; go to RD_BUS when FIFO count < FIFO_DEPTH.
- FINISH: done=1 for exactly one cycle -> IDLE. The read FIFO may still hold data after done; it drains independently. A new command may start while the FIFO still holds data.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- FIFO:
  - rd_valid = count != 0; pop when rd_valid && rd_ready.
  - A simultaneous push and pop leaves count unchanged; a push when full cannot occur; a pop when empty is ignored.
  - Read data order equals address order.
- busy = (state != IDLE).

Test Plan:
- Write 3 words, addr=0x0000_0010, data A0,A1,A2, slave acks after 2 cycles -> m_adr 0x10, 0x14, 0x18 with matching m_dat_o, m_sel=F; m_valid held until each ack; single done pulse; busy falls with done.
- Read 4 words at 0x0000_0100, rd_ready=1, slave returns 0x100+i after 5-cycle latency -> rd_data sequence 0x100..0x103 in order, m_sel=0, done after 4th ack.
- Read 12 words, FIFO_DEPTH=8, rd_ready=0 until done-wait -> exactly 8 acks then m_valid=0 (RD_STALL). Release rd_ready -> remaining 4 issued; 12 words delivered in order, no loss.
- Write with wr_valid gaps: wr_valid low 3 cycles between words -> m_valid stays low during gaps, no spurious bus write.
- cmd_len=0 -> no m_valid, done pulses one cycle after acceptance. Also start addr 0xFFFF_FFF8, len 3 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert wb_rst_i mid-read with 3 FIFO entries and m_valid=1 -> next cycle m_valid=0, rd_valid=0, busy=0, cmd_ready=1, no done pulse.
